fp_mul_int_vec_seq: RTL and testbench
=====================================

Name: fp_mul_int_vec_seq

Overview:
- Sequences a packed vector of FP16 activations and INTn weights through a small pool of shared `fp_mul_int` lanes.
- Produces a packed vector of FP32 products behind valid/ready handshakes on both sides.
- Sits between the operand streamer and the downstream accumulator or writeback.
- Trades area for latency: NumElems products are computed over NumElems/NumLanes beats.

Parameters:
- NumElems, 8, elements per vector; must be a multiple of NumLanes
- NumLanes, 2, number of `fp_mul_int` instances (FP16 x INT4 -> FP32, RNE)
- WidthA, 16, FP operand width (FP16)
- WidthB, 4, integer operand width (signed two's complement)
- WidthOut, 32, result width (FP32)
- NumBeats, NumElems/NumLanes, derived; do not override

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- in_valid_i  in  1  input vector valid
- in_ready_o  out  1  input vector accepted when valid & ready
- a_vec_i  in  NumElems*WidthA  FP16 operands; element i at [i*WidthA +: WidthA]
- b_vec_i  in  NumElems*WidthB  INT operands; element i at [i*WidthB +: WidthB]
- out_valid_o  out  1  result vector valid
- out_ready_i  in  1  downstream accepts result
- result_vec_o  out  NumElems*WidthOut  FP32 products; element i matches operand i
- busy_o  out  1  high in RUN or HOLD
- vec_cnt_o  out  32  count of result vectors handed off; wraps at 2^32

Behaviour:
- Clock and reset: one clock, `clk_i`. Reset `rst_ni` is synchronous, active-low.
- Reset values: FSM=IDLE, beat_cnt=0, out_valid_o=0, busy_o=0, result_vec_o=0, vec_cnt_o=0, operand registers=0.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i, latch a_vec_i and b_vec_i into operand registers, set beat_cnt=0, go to RUN.
- RUN:
  - in_ready_o=0.
  - Each cycle, lane l multiplies operand element beat_cnt*NumLanes+l.
  - The multiplier is combinational; the lane output is registered into result buffer slot beat_cnt*NumLanes+l at the clock edge.
  - beat_cnt increments each cycle.
  - When beat_cnt==NumBeats-1, reset beat_cnt to 0 and go to HOLD.
- HOLD:
  - out_valid_o=1; result_vec_o stable.
  - On out_ready_i, vec_cnt_o increments.
  - If in_valid_i is also high in the same cycle: in_ready_o=1, latch the new operands, go to RUN (back-to-back).
  - Otherwise go to IDLE.
  - in_ready_o = (state==IDLE) | (state==HOLD & out_ready_i). This is a combinational path from out_ready_i; it is permitted.
- Latency: vector accepted at edge t; results written at edges t+1..t+NumBeats; out_valid_o high from cycle t+NumBeats+1.
- Throughput: default config is 5 cycles per vector back-to-back, i.e. NumBeats+1.
- Result buffer rules:
  - Slots not yet written in the current vector keep their previous values.
  - result_vec_o is only guaranteed in HOLD.
  - The buffer is not cleared between vectors.
- Lanes: lane operand muxes select by beat_cnt only. No data-dependent skipping; special values (NaN, Inf, zero) take the same number of beats.
- Output handshake: out_valid_o does not drop without out_ready_i. Valid/data stay stable under backpressure indefinitely.
- Input pins: in_valid_i in RUN is ignored. The operand registers are unaffected and a_vec_i/b_vec_i are not sampled.
- Counter: vec_cnt_o wraps 0xFFFFFFFF -> 0 with no flag.
- Reset mid-operation: rst_ni low in RUN or HOLD aborts the vector. Next cycle is IDLE with all outputs at reset values; the pending result is lost and not counted.
- NumLanes==NumElems: NumBeats=1, so RUN lasts one cycle.

Test Plan:
- Single vector, default params: a=all 0x3C00 (1.0), b=all 0x3 → out_valid_o rises 5 cycles after the accepting edge; every element is 0x40400000; vec_cnt_o=1 after handshake.
- Mixed values: elem0 0xC000 × 0xF (-2×-1) → 0x40000000; elem1 0x3E00 × 0x7 → 0x41280000; elem2 0x3C00 × 0x0 → 0x00000000; elem3 0x7C00 × 0x0 → 0x7FC00000. Verify slot-to-element mapping across all beats.
- Backpressure: hold out_ready_i=0 for 10 cycles in HOLD → out_valid_o stays 1, result_vec_o stable, in_ready_o=0, in_valid_i pulses ignored; release → one vec_cnt_o increment.
- Back-to-back: in_valid_i held high with two different vectors, out_ready_i=1 → second vector accepted in the same cycle the first is handed off; outputs spaced 5 cycles; both correct; vec_cnt_o=2.
- Reset mid-RUN: drop rst_ni at beat 2 for one cycle → next cycle IDLE, out_valid_o=0, busy_o=0, result_vec_o=0, vec_cnt_o=0; a subsequent vector completes normally.
- Config NumLanes=NumElems=8 → out_valid_o 2 cycles after accept; results match the single-vector case.

Source files
------------

// File: rtl/fp_mul_int_vec_seq.sv
// Vector FP16 x signed-INT multiplier: NumLanes shared fp_mul_int lanes walk the
// operand vector over NumBeats cycles and present the FP32 product vector in HOLD.
module fp_mul_int_vec_seq #(
    parameter int NumElems = 8,
    parameter int NumLanes = 2,
    parameter int WidthA   = 16,
    parameter int WidthB   = 4,
    parameter int WidthOut = 32,
    parameter int NumBeats = NumElems / NumLanes
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [NumElems*WidthA-1:0]   a_vec_i,
    input  logic [NumElems*WidthB-1:0]   b_vec_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [NumElems*WidthOut-1:0] result_vec_o,
    output logic                         busy_o,
    output logic [31:0]                  vec_cnt_o
);

    localparam int BeatW = (NumBeats > 1) ? $clog2(NumBeats) : 1;
    localparam int ProdW = 11 + WidthB;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t                       state_q, state_d;
    logic [BeatW-1:0]             beat_cnt;
    logic [NumElems*WidthA-1:0]   a_reg;
    logic [NumElems*WidthB-1:0]   b_reg;
    logic [NumElems*WidthOut-1:0] res_buf;
    logic [31:0]                  vec_cnt;
    logic [WidthOut-1:0]          lane_out [NumLanes];
    logic                         load;
    logic                         last_beat;
    logic                         hand_off;

    // Round-to-nearest-even on a 24-bit significand; bit 24 flags mantissa overflow.
    function automatic logic [24:0] round_rne(input logic [23:0] sig, input logic guard,
                                              input logic sticky);
        logic inc;
        inc = guard & (sticky | sig[0]);
        return {1'b0, sig} + {24'd0, inc};
    endfunction

    function automatic logic [31:0] sat_pack(input logic sign, input int exp_b,
                                             input logic [22:0] mant);
        if (exp_b >= 255)
            return {sign, 8'hFF, 23'd0};
        else if (exp_b <= 0)
            return {sign, 31'd0};
        else
            return {sign, 8'(exp_b), mant};
    endfunction

    function automatic logic [31:0] fp_mul_int(input logic [15:0] a,
                                               input logic signed [WidthB-1:0] b);
        logic                sr;
        logic [4:0]          ea;
        logic [9:0]          ma;
        logic [WidthB-1:0]   mag;
        logic [10:0]         sig;
        logic [ProdW-1:0]    prod;
        logic [ProdW-1:0]    norm;
        logic [ProdW+23:0]   wide;
        logic [24:0]         rnd;
        logic [22:0]         mant;
        int                  e;
        int                  p;
        int                  exp_b;
        logic [31:0]         r;
        ea   = a[14:10];
        ma   = a[9:0];
        sr   = a[15] ^ b[WidthB-1];
        mag  = b[WidthB-1] ? (~b + 1'b1) : b;
        sig  = {(ea != 5'd0), ma};
        e    = (ea != 5'd0) ? int'(ea) - 15 : -14;
        prod = ProdW'(sig) * ProdW'(mag);
        p    = 0;
        r    = '0;
        if (ea == 5'h1F) begin
            // NaN operand or Inf x 0 gives the canonical quiet NaN
            r = (ma != 10'd0 || mag == '0) ? 32'h7FC0_0000 : {sr, 8'hFF, 23'd0};
        end else if (prod == '0) begin
            r = {sr, 31'd0};
        end else begin
            for (int i = 0; i < ProdW; i++)
                if (prod[i]) p = i;
            norm  = prod << (ProdW - 1 - p);
            wide  = {norm, 24'd0};
            exp_b = p + e - 10 + 127;
            rnd   = round_rne(wide[ProdW+23 -: 24], wide[ProdW-1], |wide[ProdW-2:0]);
            mant  = rnd[24] ? rnd[23:1] : rnd[22:0];
            if (rnd[24]) exp_b = exp_b + 1;
            r = sat_pack(sr, exp_b, mant);
        end
        return r;
    endfunction

    assign last_beat    = (beat_cnt == BeatW'(NumBeats - 1));
    assign hand_off     = (state_q == HOLD) & out_ready_i;
    assign in_ready_o   = (state_q == IDLE) | hand_off;
    assign out_valid_o  = (state_q == HOLD);
    assign busy_o       = (state_q != IDLE);
    assign result_vec_o = res_buf;
    assign vec_cnt_o    = vec_cnt;

    // Lane operand selection depends only on the beat number
    for (genvar l = 0; l < NumLanes; l++) begin : g_lane
        always_comb begin
            lane_out[l] = fp_mul_int(a_reg[(int'(beat_cnt) * NumLanes + l) * WidthA +: WidthA],
                                     b_reg[(int'(beat_cnt) * NumLanes + l) * WidthB +: WidthB]);
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_beat) state_d = HOLD;
            end
            HOLD: begin
                if (out_ready_i) begin
                    load    = in_valid_i;
                    state_d = in_valid_i ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            beat_cnt <= '0;
            vec_cnt  <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            res_buf  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                a_reg    <= a_vec_i;
                b_reg    <= b_vec_i;
                beat_cnt <= '0;
            end else if (state_q == RUN) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            // Slots not touched this beat keep their previous contents
            if (state_q == RUN) begin
                for (int l = 0; l < NumLanes; l++)
                    res_buf[(int'(beat_cnt) * NumLanes + l) * WidthOut +: WidthOut] <= lane_out[l];
            end
            if (hand_off) vec_cnt <= vec_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_fp_mul_int_vec_seq.sv
// Directed bench for fp_mul_int_vec_seq: default 2-lane instance plus an 8-lane instance.
module tb_fp_mul_int_vec_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] a_vec;
    logic [31:0]  b_vec;
    logic [255:0] result_vec;
    logic [31:0]  vec_cnt;

    logic         in_valid_8, in_ready_8, out_valid_8, out_ready_8, busy_8;
    logic [127:0] a_vec_8;
    logic [31:0]  b_vec_8;
    logic [255:0] result_vec_8;
    logic [31:0]  vec_cnt_8;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] ONES_A = {8{16'h3C00}};
    localparam logic [31:0]  B3     = {8{4'h3}};
    localparam logic [255:0] EXP3   = {8{32'h4040_0000}};

    localparam logic [127:0] MIX_A = {16'h7E00, 16'hFC00, 16'h7BFF, 16'h0001,
                                      16'h7C00, 16'h3C00, 16'h3E00, 16'hC000};
    localparam logic [31:0]  MIX_B = {4'h1, 4'h2, 4'h8, 4'h1, 4'h0, 4'h0, 4'h7, 4'hF};
    localparam logic [255:0] MIX_E = {32'h7FC0_0000, 32'hFF80_0000, 32'hC8FF_E000, 32'h3380_0000,
                                      32'h7FC0_0000, 32'h0000_0000, 32'h4128_0000, 32'h4000_0000};

    localparam logic [127:0] VB_A = {8{16'h4000}};
    localparam logic [31:0]  VB_B = {4'h3, 4'h2, 4'h1, 4'h0, 4'hF, 4'hE, 4'hD, 4'hC};
    localparam logic [255:0] VB_E = {32'h40C0_0000, 32'h4080_0000, 32'h4000_0000, 32'h0000_0000,
                                     32'hC000_0000, 32'hC080_0000, 32'hC0C0_0000, 32'hC100_0000};

    fp_mul_int_vec_seq dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_vec_i(a_vec), .b_vec_i(b_vec),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_vec_o(result_vec), .busy_o(busy), .vec_cnt_o(vec_cnt)
    );

    fp_mul_int_vec_seq #(.NumElems(8), .NumLanes(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid_8), .in_ready_o(in_ready_8),
        .a_vec_i(a_vec_8), .b_vec_i(b_vec_8),
        .out_valid_o(out_valid_8), .out_ready_i(out_ready_8),
        .result_vec_o(result_vec_8), .busy_o(busy_8), .vec_cnt_o(vec_cnt_8)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [255:0] got, input logic [255:0] exp);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s[%0d]", tag, i), 256'(got[i*32 +: 32]), 256'(exp[i*32 +: 32]));
    endtask

    // Offer a vector to the 2-lane DUT; lat = cycles from accept edge until out_valid seen
    task automatic send(input logic [127:0] a, input logic [31:0] b, output int lat);
        int n;
        @(negedge clk);
        a_vec    = a;
        b_vec    = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 256'(in_ready), 256'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int n;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a_vec       = '0;
        b_vec       = '0;
        in_valid_8  = 1'b0;
        out_ready_8 = 1'b0;
        a_vec_8     = '0;
        b_vec_8     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_result", result_vec, 256'(0));
        check("rst_vec_cnt", 256'(vec_cnt), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1));

        // single vector, 1.0 x 3
        send(ONES_A, B3, lat);
        check("single_lat", 256'(lat), 256'(5));
        check_vec("single", result_vec, EXP3);
        check("single_busy", 256'(busy), 256'(1));
        take();
        check("single_cnt", 256'(vec_cnt), 256'(1));
        check("single_idle", 256'(busy), 256'(0));

        // mixed values incl. subnormal, max, Inf, NaN
        send(MIX_A, MIX_B, lat);
        check("mix_lat", 256'(lat), 256'(5));
        check_vec("mix", result_vec, MIX_E);
        take();
        check("mix_cnt", 256'(vec_cnt), 256'(2));

        // backpressure with ignored in_valid pulses
        send(ONES_A, B3, lat);
        check("bp_lat", 256'(lat), 256'(5));
        for (int c = 0; c < 10; c++) begin
            check($sformatf("bp_valid%0d", c), 256'(out_valid), 256'(1));
            check($sformatf("bp_ready%0d", c), 256'(in_ready), 256'(0));
            check($sformatf("bp_data%0d", c), result_vec, EXP3);
            check($sformatf("bp_cnt%0d", c), 256'(vec_cnt), 256'(2));
            a_vec    = VB_A;
            b_vec    = VB_B;
            in_valid = c[0];
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp_data_end", result_vec, EXP3);
        take();
        check("bp_cnt", 256'(vec_cnt), 256'(3));
        check("bp_idle", 256'(busy), 256'(0));

        // back-to-back: second vector accepted on the hand-off edge of the first
        @(negedge clk);
        a_vec     = MIX_A;
        b_vec     = MIX_B;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        a_vec = VB_A;
        b_vec = VB_B;
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check("b2b_lat1", 256'(lat), 256'(5));
        check_vec("b2b_first", result_vec, MIX_E);
        check("b2b_in_ready", 256'(in_ready), 256'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check("b2b_lat2", 256'(lat), 256'(5));
        check("b2b_cnt_mid", 256'(vec_cnt), 256'(4));
        check_vec("b2b_second", result_vec, VB_E);
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("b2b_cnt", 256'(vec_cnt), 256'(5));
        check("b2b_idle", 256'(busy), 256'(0));

        // reset during beat 2
        a_vec    = VB_A;
        b_vec    = VB_B;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("mid_busy_before", 256'(busy), 256'(1));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_out_valid", 256'(out_valid), 256'(0));
        check("mid_busy", 256'(busy), 256'(0));
        check("mid_result", result_vec, 256'(0));
        check("mid_vec_cnt", 256'(vec_cnt), 256'(0));
        check("mid_in_ready", 256'(in_ready), 256'(1));
        send(MIX_A, MIX_B, lat);
        check("after_rst_lat", 256'(lat), 256'(5));
        check_vec("after_rst", result_vec, MIX_E);
        take();
        check("after_rst_cnt", 256'(vec_cnt), 256'(1));

        // 8-lane instance: single beat
        @(negedge clk);
        a_vec_8    = ONES_A;
        b_vec_8    = B3;
        in_valid_8 = 1'b1;
        check("l8_ready", 256'(in_ready_8), 256'(1));
        @(posedge clk);
        #1 in_valid_8 = 1'b0;
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (out_valid_8) break;
        end
        check("l8_lat", 256'(lat), 256'(2));
        check_vec("l8", result_vec_8, EXP3);
        out_ready_8 = 1'b1;
        @(posedge clk);
        #1 out_ready_8 = 1'b0;
        @(negedge clk);
        check("l8_cnt", 256'(vec_cnt_8), 256'(1));
        check("l8_idle", 256'(busy_8), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
